// File: rtl/matrix_engine_pkg.sv
// Shared definitions for the matrix engine: bus widths, opcodes, sequencer
// state encodings and abort cause codes.
package matrix_engine_pkg;

  localparam int MATRIX_W = 256;
  localparam int ADDR_W   = 8;

  localparam logic [7:0] OP_ADD       = 8'h00;
  localparam logic [7:0] OP_SUB       = 8'h01;
  localparam logic [7:0] OP_TRANSPOSE = 8'h02;
  localparam logic [7:0] OP_SCALE     = 8'h03;
  localparam logic [7:0] OP_MUL       = 8'h04;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_RD_A     = 4'd1;
  localparam state_t ST_CAP_A    = 4'd2;
  localparam state_t ST_RD_B     = 4'd3;
  localparam state_t ST_CAP_B    = 4'd4;
  localparam state_t ST_EXEC     = 4'd5;
  localparam state_t ST_WAIT_ALU = 4'd6;
  localparam state_t ST_WRITE    = 4'd7;
  localparam state_t ST_DONE     = 4'd8;
  localparam state_t ST_ERR      = 4'd9;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  function automatic logic opcode_legal(input logic [7:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_TRANSPOSE, OP_SCALE, OP_MUL: ok = 1'b1;
      default:                                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/matrix_alu_watchdog.sv
// Clearable cycle counter guarding the wait for the ALU result; expire is
// raised in the wait cycle in which the count reaches TIMEOUT.
module matrix_alu_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic nReset,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam logic [8:0] LIMIT = 9'(TIMEOUT);

  logic [8:0] count_r;

  // The start cycle is counted as the first one, so an abort lands TIMEOUT cycles after it.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      count_r <= 9'd0;
    end else if (clear) begin
      count_r <= 9'd1;
    end else if (inc && (count_r != 9'h1FF)) begin
      count_r <= count_r + 9'd1;
    end
  end

  assign expire = inc && ((count_r + 9'd1) >= LIMIT);

endmodule

// File: rtl/matrix_exec_sequencer.sv
// Matrix instruction sequencer: fetches operands from matrix memory, runs the
// matrix ALU and writes the result back; sole master of the memory control lines.
module matrix_exec_sequencer
  import matrix_engine_pkg::*;
#(
  parameter int ALU_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                instrValid,
  output logic                instrReady,
  input  logic [7:0]          opcode,
  input  logic [ADDR_W-1:0]   src1,
  input  logic [ADDR_W-1:0]   src2,
  input  logic [ADDR_W-1:0]   dest,
  output logic                nMatrixMemEnable,
  output logic                ReadnWrite,
  output logic [ADDR_W-1:0]   address,
  input  logic [MATRIX_W-1:0] memRdData,
  output logic [MATRIX_W-1:0] memWrData,
  output logic                memWrDataEn,
  output logic                aluStart,
  output logic [7:0]          aluOpcode,
  output logic [MATRIX_W-1:0] aluOperandA,
  output logic [MATRIX_W-1:0] aluOperandB,
  input  logic                aluDone,
  input  logic [MATRIX_W-1:0] aluResult,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [1:0]          errCode
);

  state_t              state_r, state_nxt_s;
  logic                accept_s, wd_expire_s, timeout_abort_s;
  logic [7:0]          opcode_r;
  logic [ADDR_W-1:0]   src1_r, src2_r, dest_r;
  logic [MATRIX_W-1:0] operand_a_r, operand_b_r;
  logic [1:0]          err_code_r;

  logic                mem_en_n_s, rnw_s, wr_data_en_s, alu_start_s, done_s, error_s;
  logic [ADDR_W-1:0]   addr_s;
  logic [MATRIX_W-1:0] wr_data_s;
  logic                mem_en_n_r, rnw_r, wr_data_en_r, alu_start_r, done_r, error_r;
  logic                ready_r, busy_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [MATRIX_W-1:0] wr_data_r;

  assign accept_s        = (state_r == ST_IDLE) && instrValid;
  assign timeout_abort_s = (state_r == ST_WAIT_ALU) && !aluDone && wd_expire_s;

  matrix_alu_watchdog #(.TIMEOUT(ALU_TIMEOUT)) u_watchdog (
    .clk    (clk),
    .nReset (nReset),
    .clear  (state_r == ST_EXEC),
    .inc    (state_r == ST_WAIT_ALU),
    .expire (wd_expire_s)
  );

  // Next-state selection for the instruction flow.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (instrValid) begin
          state_nxt_s = opcode_legal(opcode) ? ST_RD_A : ST_ERR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD_A:  state_nxt_s = ST_CAP_A;
      ST_CAP_A: state_nxt_s = (opcode_r == OP_TRANSPOSE) ? ST_EXEC : ST_RD_B;
      ST_RD_B:  state_nxt_s = ST_CAP_B;
      ST_CAP_B: state_nxt_s = ST_EXEC;
      ST_EXEC:  state_nxt_s = ST_WAIT_ALU;
      ST_WAIT_ALU: begin
        if (aluDone) begin
          state_nxt_s = ST_WRITE;
        end else if (wd_expire_s) begin
          state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_WAIT_ALU;
        end
      end
      ST_WRITE: state_nxt_s = ST_DONE;
      ST_DONE:  state_nxt_s = ST_IDLE;
      ST_ERR:   state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Output values for the state being entered, so every output is a flop aligned with its state.
  always_comb begin
    mem_en_n_s   = 1'b1;
    rnw_s        = 1'b1;
    addr_s       = {ADDR_W{1'b0}};
    wr_data_en_s = 1'b0;
    wr_data_s    = {MATRIX_W{1'b0}};
    alu_start_s  = 1'b0;
    done_s       = 1'b0;
    error_s      = 1'b0;
    case (state_nxt_s)
      ST_RD_A: begin
        mem_en_n_s = 1'b0;
        addr_s     = src1;
      end
      ST_CAP_A: begin
        mem_en_n_s = 1'b0;
        addr_s     = src1_r;
      end
      ST_RD_B, ST_CAP_B: begin
        mem_en_n_s = 1'b0;
        addr_s     = src2_r;
      end
      ST_EXEC:  alu_start_s = 1'b1;
      ST_WRITE: begin
        mem_en_n_s   = 1'b0;
        rnw_s        = 1'b0;
        addr_s       = dest_r;
        wr_data_en_s = 1'b1;
        wr_data_s    = aluResult;
      end
      ST_DONE: done_s  = 1'b1;
      ST_ERR:  error_s = 1'b1;
      default: mem_en_n_s = 1'b1;
    endcase
  end

  // State, latched instruction fields, captured operands and abort cause.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_r     <= ST_IDLE;
      opcode_r    <= 8'd0;
      src1_r      <= {ADDR_W{1'b0}};
      src2_r      <= {ADDR_W{1'b0}};
      dest_r      <= {ADDR_W{1'b0}};
      operand_a_r <= {MATRIX_W{1'b0}};
      operand_b_r <= {MATRIX_W{1'b0}};
      err_code_r  <= ERR_NONE;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        opcode_r    <= opcode;
        src1_r      <= src1;
        src2_r      <= src2;
        dest_r      <= dest;
        operand_a_r <= {MATRIX_W{1'b0}};
        operand_b_r <= {MATRIX_W{1'b0}};
        err_code_r  <= opcode_legal(opcode) ? ERR_NONE : ERR_ILLEGAL;
      end else if (timeout_abort_s) begin
        err_code_r <= ERR_TIMEOUT;
      end
      if (state_r == ST_CAP_A) begin
        operand_a_r <= memRdData;
      end
      if (state_r == ST_CAP_B) begin
        operand_b_r <= memRdData;
      end
    end
  end

  // Registered interface outputs.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      mem_en_n_r   <= 1'b1;
      rnw_r        <= 1'b1;
      addr_r       <= {ADDR_W{1'b0}};
      wr_data_en_r <= 1'b0;
      wr_data_r    <= {MATRIX_W{1'b0}};
      alu_start_r  <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      ready_r      <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      mem_en_n_r   <= mem_en_n_s;
      rnw_r        <= rnw_s;
      addr_r       <= addr_s;
      wr_data_en_r <= wr_data_en_s;
      wr_data_r    <= wr_data_s;
      alu_start_r  <= alu_start_s;
      done_r       <= done_s;
      error_r      <= error_s;
      ready_r      <= (state_nxt_s == ST_IDLE);
      busy_r       <= (state_nxt_s != ST_IDLE);
    end
  end

  assign instrReady       = ready_r;
  assign busy             = busy_r;
  assign nMatrixMemEnable = mem_en_n_r;
  assign ReadnWrite       = rnw_r;
  assign address          = addr_r;
  assign memWrData        = wr_data_r;
  assign memWrDataEn      = wr_data_en_r;
  assign aluStart         = alu_start_r;
  assign aluOpcode        = opcode_r;
  assign aluOperandA      = operand_a_r;
  assign aluOperandB      = operand_b_r;
  assign done             = done_r;
  assign error            = error_r;
  assign errCode          = err_code_r;

endmodule

// File: doc/matrix_exec_sequencer.md
# matrix_exec_sequencer

Sequencer sitting between the instruction decoder and the matrix memory and matrix ALU of the simple matrix engine. It accepts one instruction at a time: opcode, two source addresses and a destination address. It fetches the operands from matrix memory over the 256-bit data path, starts the ALU, waits for its result, and writes the result back. It is the only master of the memory's enable, read/write and address lines.

## Interface
- ALU_TIMEOUT, 255: max cycles spent waiting for aluDone before aborting.
- MATRIX_W, 256: matrix word width (16 × 16-bit elements).
- clk  in  1  clock; all state changes on posedge.
- nReset  in  1  reset; asynchronous, active-low.
- instrValid  in  1  instruction present.
- instrReady  out  1  sequencer can accept; high only in IDLE.
- opcode  in  8  operation code.
- src1  in  8  first operand address.
- src2  in  8  second operand address.
- dest  in  8  result address.
- nMatrixMemEnable  out  1  memory enable, active-low.
- ReadnWrite  out  1  1 = read, 0 = write.
- address  out  8  memory address.
- memRdData  in  MATRIX_W  memory read data (bus as seen by the sequencer).
- memWrData  out  MATRIX_W  write data.
- memWrDataEn  out  1  drive enable for memWrData onto the shared bus (tristate at top level).
- aluStart  out  1  one-cycle start pulse.
- aluOpcode  out  8  opcode to ALU, held from EXEC through WAIT_ALU.
- aluOperandA  out  MATRIX_W  first operand to ALU, held from EXEC through WAIT_ALU.
- aluOperandB  out  MATRIX_W  second operand to ALU, held from EXEC through WAIT_ALU.
- aluDone  in  1  result valid.
- aluResult  in  MATRIX_W  result.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on abort.
- errCode  out  2  cause of the last abort: 0 none, 1 illegal opcode, 2 ALU timeout; held until the next accept.

## Operation
- Opcodes:
  - 0x00 ADD, 0x01 SUB, 0x03 SCALE, 0x04 MUL: two operands.
  - 0x02 TRANSPOSE: one operand. aluOperandB = 0.
  - Any other value is illegal.
- Reset values: nMatrixMemEnable=1, ReadnWrite=1, address=0, memWrDataEn=0, memWrData=0, aluStart=0, operands=0, busy=0, done=0, error=0, errCode=0, state IDLE (so instrReady=1 once reset is released).
- IDLE: on instrValid, latch opcode/src1/src2/dest and clear errCode.
  - Legal opcode -> RD_A.
  - Illegal opcode -> ERR with errCode=1; no memory access.
- RD_A: nMatrixMemEnable=0, ReadnWrite=1, address=src1. -> CAP_A.
- CAP_A: same drive as RD_A; capture memRdData into operand A at end of cycle.
  - TRANSPOSE -> EXEC.
  - Otherwise -> RD_B.
- RD_B / CAP_B: as RD_A / CAP_A, with address=src2. CAP_B -> EXEC.
- EXEC: aluStart=1; memory disabled. Clear the watchdog counter. -> WAIT_ALU.
- WAIT_ALU: the watchdog increments each cycle.
  - aluDone: capture aluResult. -> WRITE.
  - Counter reaches ALU_TIMEOUT: -> ERR with errCode=2. Takes priority only if aluDone is not asserted in the same cycle.
- WRITE: nMatrixMemEnable=0, ReadnWrite=0, address=dest, memWrDataEn=1, memWrData=result. One cycle. -> DONE.
- DONE: done=1. -> IDLE.
- ERR: error=1. -> IDLE.
- Addresses are passed through unchecked; addresses ≥10 select the memory's result register.
- aluDone outside WAIT_ALU is ignored.

## Timing
- Memory enable is never asserted outside RD_A, CAP_A, RD_B, CAP_B and WRITE.
- memWrDataEn is high only in WRITE, so the sequencer never drives the bus while the memory reads.
- Memory read latency is 1 cycle: data is registered at the RD edge and valid while enable stays low in CAP. This is why CAP keeps enable asserted.
- Latency, with acceptance in cycle 0 and a 1-cycle ALU:
  - Two-operand op: done in cycle 8.
  - TRANSPOSE: done in cycle 6.
  - Illegal opcode: error in cycle 1.
- Back-to-back: the next instruction can be accepted the cycle after DONE or ERR.
- Asynchronous reset in any state: all outputs go to reset values immediately. Latched operands are discarded, no write is issued, and the instruction is lost.

## Structure
- Shared package matrix_engine_pkg holds: opcode constants, the state enum (IDLE, RD_A, CAP_A, RD_B, CAP_B, EXEC, WAIT_ALU, WRITE, DONE, ERR), errCode constants, MATRIX_W, and ADDR_W=8.
- One sub-module, matrix_alu_watchdog: a clearable counter that raises an expire flag at ALU_TIMEOUT.

## Test plan
- Reset release -> instrReady=1, nMatrixMemEnable=1, ReadnWrite=1, memWrDataEn=0, busy=0.
- ADD with src1=0, src2=1, dest=2, ALU model returning A+B after 1 cycle:
  - Memory sees read at address 0 (cycles 1–2), read at address 1 (cycles 3–4), write at address 2 in cycle 7.
  - Word at address 2 = elementwise sum of the two preloaded matrices.
  - done pulses in cycle 8.
- TRANSPOSE with src1=0, dest=10 -> no read of src2; write to address 10 in cycle 5; done in cycle 6; aluOperandB=0.
- Opcode 0x7F -> error in cycle 1, errCode=1, memory never enabled.
- aluDone held low with ALU_TIMEOUT=8 -> error 8 cycles after EXEC, errCode=2, no WRITE cycle.
- nReset asserted in WAIT_ALU, then released with instrValid held -> no write; outputs at reset values; instruction accepted in the first IDLE cycle after release.
